adaboost_weight_sequencer: RTL and testbench

// - Controller in front of the three AdaBoost bagging weight memories and classifiers.
// - Accepts one host weight stream (valid/ready, 2-bit bank select) and schedules the writes into banks 0..2, auto-incrementing each bank's address.
// - On run_start, sweeps all three banks with read addresses in lockstep while holding classifier enable.
// - Waits for all three classifiers to report ready, then pulses done.

---
 rtl/adaboost_weight_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_adaboost_weight_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adaboost_weight_sequencer.sv
// Weight-load and inference-sweep sequencer for the three AdaBoost bagging banks.
// Define ADA_WSEQ_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT cycles).
//
//   state  | meaning
//   IDLE   | waiting for load_start / run_start
//   LOAD   | accepting host words, writing banks 0..2
//   RUN    | lockstep read sweep of all banks, cls_en high
//   WAIT   | waiting for all three classifiers to report ready
//   DONE   | one-cycle done pulse
module adaboost_weight_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int WW = 9
`ifdef ADA_WSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          run_start,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [1:0]    host_sel,
  input  logic [WW-1:0] host_weight,
  output logic [2:0]    mem_write,
  output logic [2:0]    mem_read,
  output logic [AW-1:0] mem_addr0,
  output logic [AW-1:0] mem_addr1,
  output logic [AW-1:0] mem_addr2,
  output logic [WW-1:0] mem_wdata,
  output logic          cls_en,
  input  logic [2:0]    cls_ready,
  output logic          busy,
  output logic          loaded,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;

  // Bank counters need one extra bit so they can hold DEPTH itself.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [AW-1:0] addr_q [3];
  logic [AW-1:0] addr_d [3];
  logic [WW-1:0] wdata_q, wdata_d;
  logic [2:0]    write_q, write_d;
  logic [2:0]    read_q, read_d;
  logic          cls_en_q, cls_en_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          loaded_q, loaded_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef ADA_WSEQ_TIMEOUT_EN
  logic [7:0]    wd_q, wd_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = '0;
    read_d   = read_q;
    cls_en_d = cls_en_q;
    ready_d  = ready_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef ADA_WSEQ_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d  = S_LOAD;
          ready_d  = 1'b1;
          loaded_d = 1'b0;
          err_d    = 1'b0;
          for (int i = 0; i < 3; i++) cnt_d[i] = '0;
        end else if (run_start) begin
          if (loaded_q) begin
            state_d  = S_RUN;
            read_d   = 3'b111;
            cls_en_d = 1'b1;
            for (int i = 0; i < 3; i++) addr_d[i] = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (host_valid && ready_q) begin
          // sel==3 matches no bank and falls through to the error path.
          err_d = 1'b1;
          for (int i = 0; i < 3; i++) begin
            if (host_sel == 2'(i) && cnt_q[i] != FULL) begin
              err_d      = err_q;
              write_d[i] = 1'b1;
              addr_d[i]  = cnt_q[i][AW-1:0];
              wdata_d    = host_weight;
              cnt_d[i]   = cnt_q[i] + 1'b1;
            end
          end
        end
        if (cnt_d[0] == FULL && cnt_d[1] == FULL && cnt_d[2] == FULL) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          loaded_d = 1'b1;
        end
      end
      S_RUN: begin
        if (addr_q[0] == LAST) begin
          state_d  = S_WAIT;
          read_d   = '0;
          cls_en_d = 1'b0;
          for (int i = 0; i < 3; i++) addr_d[i] = '0;
`ifdef ADA_WSEQ_TIMEOUT_EN
          wd_d = 8'(TIMEOUT - 1);
`endif
        end else begin
          for (int i = 0; i < 3; i++) addr_d[i] = addr_q[0] + 1'b1;
        end
      end
      S_WAIT: begin
        if (cls_ready == 3'b111) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`ifdef ADA_WSEQ_TIMEOUT_EN
        else if (wd_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      wdata_q  <= '0;
      write_q  <= '0;
      read_q   <= '0;
      cls_en_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ADA_WSEQ_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      read_q   <= read_d;
      cls_en_q <= cls_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef ADA_WSEQ_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign host_ready = ready_q;
  assign mem_write  = write_q;
  assign mem_read   = read_q;
  assign mem_addr0  = addr_q[0];
  assign mem_addr1  = addr_q[1];
  assign mem_addr2  = addr_q[2];
  assign mem_wdata  = wdata_q;
  assign cls_en     = cls_en_q;
  assign busy       = busy_q;
  assign loaded     = loaded_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_adaboost_weight_sequencer.sv
// Randomized self-checking bench for adaboost_weight_sequencer against a
// bank-count / sweep-timing reference model.
module tb_adaboost_weight_sequencer;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int WW = 9;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          run_start = 1'b0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [1:0]    host_sel = '0;
  logic [WW-1:0] host_weight = '0;
  logic [2:0]    mem_write, mem_read;
  logic [AW-1:0] mem_addr0, mem_addr1, mem_addr2;
  logic [WW-1:0] mem_wdata;
  logic          cls_en;
  logic [2:0]    cls_ready = '0;
  logic          busy, loaded, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int m_err = 0;

  adaboost_weight_sequencer dut (
    .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
    .host_valid(host_valid), .host_ready(host_ready), .host_sel(host_sel),
    .host_weight(host_weight), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_wdata(mem_wdata), .cls_en(cls_en), .cls_ready(cls_ready),
    .busy(busy), .loaded(loaded), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int addr_of(input int b);
    if (b == 0) return int'(mem_addr0);
    if (b == 1) return int'(mem_addr1);
    return int'(mem_addr2);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, host_ready, 0);
    chk({tag, "_write"}, mem_write, 0);
    chk({tag, "_read"}, mem_read, 0);
    chk({tag, "_addr"}, mem_addr0 | mem_addr1 | mem_addr2, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_flags"}, {cls_en, busy, loaded, done, err}, 0);
  endtask

  // mode 0: round robin sel, weight=i; mode 1: random; mode 2: bank1 overfill + sel 3
  task automatic do_load(input int mode, input int max_cyc);
    int cnt [3];
    int w = 0;
    bit finished = 0;
    bit exp_ready = 1;
    bit exp_wv = 0;
    int exp_b = 0, exp_a = 0;
    logic [WW-1:0] exp_d = '0;
    bit v;
    logic [1:0] s;
    logic [WW-1:0] wt;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    m_err = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      chk("host_ready", host_ready, int'(exp_ready));
      chk("mem_write", mem_write, exp_wv ? (1 << exp_b) : 0);
      if (exp_wv) begin
        chk("wr_addr", addr_of(exp_b), exp_a);
        chk("wr_data", mem_wdata, exp_d);
      end
      chk("load_err", err, m_err);
      if (!exp_ready) begin
        finished = 1;
        break;
      end
      chk("load_busy", busy, 1);
      chk("load_loaded", loaded, 0);
      case (mode)
        0: begin v = 1; s = 2'(w % 3); wt = WW'(w); end
        1: begin v = ($urandom_range(0, 3) != 0); s = 2'($urandom_range(0, 3)); wt = WW'($urandom); end
        default: begin
          v = 1;
          wt = WW'($urandom);
          if (w < 33) s = 2'd1;
          else if (w == 33) s = 2'd3;
          else s = (w % 2 == 1) ? 2'd0 : 2'd2;
        end
      endcase
      host_valid = v;
      host_sel = s;
      host_weight = wt;
      exp_wv = 0;
      if (v) begin
        if (s < 3 && cnt[s] < DEPTH) begin
          exp_wv = 1; exp_b = int'(s); exp_a = cnt[s]; exp_d = wt;
          cnt[s]++;
        end else begin
          m_err = 1;
        end
        w++;
      end
      if (cnt[0] == DEPTH && cnt[1] == DEPTH && cnt[2] == DEPTH) exp_ready = 0;
      step();
    end
    host_valid = 1'b0;
    chk("load_finished", int'(finished), 1);
    chk("loaded_set", loaded, 1);
    chk("load_idle_busy", busy, 0);
    step();
    chk("idle_no_write", mem_write, 0);
  endtask

  task automatic do_run(input int rd, input bit hang);
    int done_at;
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("cls_en", cls_en, 1);
      chk("mem_read", mem_read, 7);
      chk("addr0", mem_addr0, k);
      chk("addr1", mem_addr1, k);
      chk("addr2", mem_addr2, k);
      chk("run_busy", busy, 1);
      chk("run_write", mem_write, 0);
      chk("run_done", done, 0);
      load_start = (k == 10);
      run_start = (k == 10);
      step();
    end
    load_start = 1'b0;
    run_start = 1'b0;
    done_at = hang ? TIMEOUT : rd + 1;
    for (int j = 0; j <= done_at; j++) begin
      chk("wait_cls_en", cls_en, 0);
      chk("wait_read", mem_read, 0);
      chk("done", done, int'(j == done_at));
      chk("wait_busy", busy, 1);
      if (hang) cls_ready = 3'b011;
      else cls_ready = (j >= rd) ? 3'b111 : 3'($urandom_range(0, 6));
      step();
    end
    cls_ready = '0;
    if (hang) m_err = 1;
    chk("done_low", done, 0);
    chk("post_busy", busy, 0);
    chk("post_err", err, m_err);
    chk("post_loaded", loaded, 1);
  endtask

  initial begin
    #1;
    chk_all_zero("in_reset");
    step();
    rst = 1'b1;
    step();
    chk_all_zero("reset");

    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("early_run_err", err, 1);
    chk("early_run_busy", busy, 0);
    step();
    chk("early_run_idle", busy, 0);

    do_load(0, 400);
    do_run(1, 0);
    for (int r = 0; r < 3; r++) do_run($urandom_range(0, 6), 0);

    do_load(2, 400);
    chk("overfill_err", err, 1);
    do_load(1, 3000);
    do_run($urandom_range(0, 4), 0);
    do_load(0, 400);
    chk("err_cleared", err, 0);

`ifdef ADA_WSEQ_TIMEOUT_EN
    do_run(0, 1);
    do_run(2, 0);
`endif

    run_start = 1'b1;
    step();
    run_start = 1'b0;
    repeat (5) step();
    chk("pre_rst_cls_en", cls_en, 1);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_run_rst");
    step();
    rst = 1'b1;
    step();
    chk_all_zero("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
